// File: rtl/dbf_pkg.sv
// -----------------------------------------------------------------------------
// dbf_pkg
// Shared definitions for the digital beamformer fine-delay / apodization slice:
// parameter defaults, output geometry and the control state enumeration.
// No ports; imported by fine_interp_apod and fine_lut_ram.
// -----------------------------------------------------------------------------
package dbf_pkg;

  localparam int DEF_INPUT_WD  = 14;
  localparam int DEF_FD_OUT_WD = 16;
  localparam int DEF_APO_WD    = 16;
  localparam int DEF_ADDR_WD   = 4;
  localparam int DEF_FRAC_WD   = 8;
  localparam int DEF_ZONE_LEN  = 64;

  // Beamformed output width and the Q1.15 alignment used when apodization
  // is compiled out (unity weight).
  localparam int DBF_WD       = 32;
  localparam int APO_SHIFT    = 15;

  // Number of cycles spent in DRAIN before returning to IDLE.
  localparam int DRAIN_CYCLES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } dbf_state_e;

endpackage

// File: rtl/fine_lut_ram.sv
// -----------------------------------------------------------------------------
// fine_lut_ram
// Focal-zone fine-delay fraction table: one write port, one synchronous
// registered read port. A read and write to the same address in the same
// cycle returns the old contents (read-first). Table contents are not reset.
// Ports:
//   clk    - clock
//   rst    - asynchronous active-high reset (clears the read register only)
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - registered read data
// -----------------------------------------------------------------------------
module fine_lut_ram
  import dbf_pkg::*;
#(
  parameter int ADDR_WD = DEF_ADDR_WD,
  parameter int DATA_WD = DEF_FRAC_WD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [ADDR_WD-1:0] waddr,
  input  logic [DATA_WD-1:0] wdata,
  input  logic [ADDR_WD-1:0] raddr,
  output logic [DATA_WD-1:0] rdata
);

  logic [DATA_WD-1:0] mem [0:(1<<ADDR_WD)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Non-blocking read of the same array gives read-first behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fine_interp_apod.sv
// -----------------------------------------------------------------------------
// fine_interp_apod
// Fine-delay linear interpolator with per-focal-zone fraction and optional
// apodization weighting for one receive channel.
//   fine_dout = (x[n] <<< (FD_OUT_WD-INPUT_WD))
//             + (((x[n-1]-x[n]) * f) >>> (FRAC_WD-(FD_OUT_WD-INPUT_WD)))
// f comes from a zone-indexed LUT; the zone advances every ZONE_LEN accepted
// samples. fine_dout appears 3 cycles after acceptance, dbf_dout one later.
// Build option: define FINE_APOD_EN to multiply fine_dout by apo_din;
// otherwise dbf_dout is fine_dout scaled by unity Q1.15 and apo_din is unused.
// Ports:
//   clk, rst_n        - clock; asynchronous reset, active-HIGH despite name
//   start, tx_en      - receive window; transmit active (blocks input)
//   fine_din(_valid)  - signed coarse-delayed sample
//   lut_addr/we/wdata - fraction table write port (honoured in IDLE only)
//   apo_din           - signed Q1.15 apodization weight
//   fine_dout(_valid) - interpolated sample
//   dbf_dout(_valid)  - weighted sample
// -----------------------------------------------------------------------------
module fine_interp_apod
  import dbf_pkg::*;
#(
  parameter int INPUT_WD  = DEF_INPUT_WD,
  parameter int FD_OUT_WD = DEF_FD_OUT_WD,
  parameter int APO_WD    = DEF_APO_WD,
  parameter int ADDR_WD   = DEF_ADDR_WD,
  parameter int FRAC_WD   = DEF_FRAC_WD,
  parameter int ZONE_LEN  = DEF_ZONE_LEN
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        tx_en,
  input  logic signed [INPUT_WD-1:0]  fine_din,
  input  logic                        fine_din_valid,
  input  logic [ADDR_WD-1:0]          lut_addr,
  input  logic                        lut_we,
  input  logic [FRAC_WD-1:0]          lut_wdata,
  input  logic signed [APO_WD-1:0]    apo_din,
  output logic signed [FD_OUT_WD-1:0] fine_dout,
  output logic                        fine_dout_valid,
  output logic signed [DBF_WD-1:0]    dbf_dout,
  output logic                        dbf_dout_valid
);

  localparam int NUM_ZONES = 1 << ADDR_WD;
  localparam int UP_SH     = FD_OUT_WD - INPUT_WD;
  localparam int DN_SH     = FRAC_WD - UP_SH;
  localparam int DIFF_WD   = INPUT_WD + 1;
  localparam int PROD_WD   = DIFF_WD + FRAC_WD + 1;
  localparam int SUM_WD    = ((PROD_WD > FD_OUT_WD) ? PROD_WD : FD_OUT_WD) + 1;
  localparam int CNT_WD    = (ZONE_LEN > 1) ? $clog2(ZONE_LEN) : 1;

  dbf_state_e state_q, state_d;
  logic [1:0] drain_cnt;

  logic accept, lut_wr_en, run_clear;

  logic [CNT_WD-1:0]         samp_cnt;
  logic [ADDR_WD-1:0]        zone_cnt;
  logic signed [INPUT_WD-1:0] hist;

  logic [FRAC_WD-1:0]         frac_s1;
  logic signed [INPUT_WD-1:0] x_s1, xp_s1;
  logic                       v_s1;

  logic signed [DIFF_WD-1:0]  diff;
  logic signed [FRAC_WD:0]    frac_sx;
  logic signed [PROD_WD-1:0]  prod;

  logic signed [PROD_WD-1:0]  prod_s2;
  logic signed [INPUT_WD-1:0] x_s2;
  logic                       v_s2;

  logic signed [FD_OUT_WD-1:0] sum_s3;
  logic                        v_s3;

  logic signed [DBF_WD-1:0] dbf_next;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (!start) state_d = DRAIN;
      DRAIN: begin
        if (start) begin
          state_d = RUN;
        end else if (drain_cnt == 2'(DRAIN_CYCLES - 1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept    = fine_din_valid && !tx_en && (state_q == RUN);
    lut_wr_en = lut_we && (state_q == IDLE);
    run_clear = start && (state_q == IDLE);
  end

  // Counts cycles spent in DRAIN; the pipeline keeps flowing meanwhile, so
  // samples accepted before start dropped still reach the outputs.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      drain_cnt <= '0;
    end else if (state_q == DRAIN) begin
      drain_cnt <= drain_cnt + 2'd1;
    end else begin
      drain_cnt <= '0;
    end
  end

  // ---------------- zone tracking and sample history ----------------
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      samp_cnt <= '0;
      zone_cnt <= '0;
      hist     <= '0;
    end else if (run_clear) begin
      samp_cnt <= '0;
      zone_cnt <= '0;
      hist     <= '0;
    end else if (accept) begin
      hist <= fine_din;
      if (samp_cnt == CNT_WD'(ZONE_LEN - 1)) begin
        samp_cnt <= '0;
        if (zone_cnt != ADDR_WD'(NUM_ZONES - 1)) begin
          zone_cnt <= zone_cnt + 1'b1;
        end
      end else begin
        samp_cnt <= samp_cnt + 1'b1;
      end
    end
  end

  // Read address is the zone of the sample being accepted, so the fraction
  // lands in stage 1 alongside that sample.
  fine_lut_ram #(
    .ADDR_WD (ADDR_WD),
    .DATA_WD (FRAC_WD)
  ) u_lut (
    .clk   (clk),
    .rst   (rst_n),
    .we    (lut_wr_en),
    .waddr (lut_addr),
    .wdata (lut_wdata),
    .raddr (zone_cnt),
    .rdata (frac_s1)
  );

  // ---------------- interpolation pipeline ----------------
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      x_s1  <= '0;
      xp_s1 <= '0;
      v_s1  <= 1'b0;
    end else begin
      x_s1  <= fine_din;
      xp_s1 <= hist;
      v_s1  <= accept;
    end
  end

  always_comb begin
    diff    = {xp_s1[INPUT_WD-1], xp_s1} - {x_s1[INPUT_WD-1], x_s1};
    frac_sx = {1'b0, frac_s1};
    prod    = diff * frac_sx;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      prod_s2 <= '0;
      x_s2    <= '0;
      v_s2    <= 1'b0;
    end else begin
      prod_s2 <= prod;
      x_s2    <= x_s1;
      v_s2    <= v_s1;
    end
  end

  // Arithmetic right shift floors; the sum is formed wide then truncated.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sum_s3 <= '0;
      v_s3   <= 1'b0;
    end else begin
      sum_s3 <= FD_OUT_WD'((SUM_WD'(x_s2) <<< UP_SH) + SUM_WD'(prod_s2 >>> DN_SH));
      v_s3   <= v_s2;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      fine_dout       <= '0;
      fine_dout_valid <= 1'b0;
    end else begin
      fine_dout       <= v_s3 ? sum_s3 : '0;
      fine_dout_valid <= v_s3;
    end
  end

  // ---------------- apodization ----------------
`ifdef FINE_APOD_EN
  logic signed [FD_OUT_WD+APO_WD-1:0] apo_prod;
  always_comb begin
    apo_prod = fine_dout * apo_din;
    dbf_next = DBF_WD'(apo_prod);
  end
`else
  logic unused_apo;
  assign unused_apo = ^apo_din;
  always_comb begin
    dbf_next = DBF_WD'(fine_dout) <<< APO_SHIFT;
  end
`endif

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      dbf_dout       <= '0;
      dbf_dout_valid <= 1'b0;
    end else begin
      dbf_dout       <= fine_dout_valid ? dbf_next : '0;
      dbf_dout_valid <= fine_dout_valid;
    end
  end

endmodule
